// File: rtl/istra_stream_decoder.sv
// istra_stream_decoder
//
// Integrates the signed stochastic output stream of the ISTRA iteration cell over a
// window of 2**WIN_LOG2 clocks and presents the two's-complement sum on a
// valid/ready handshake. A completed window is dropped, and OVERRUN is set, when
// the previous result is still waiting and the consumer is not accepting it.
//
// Optional feature: define ISTRA_DEC_SIGNMAG_EN to add the OUT_MAG / SIGN_OUT
// sign-magnitude copy of the result. It is registered alongside OUT_VAL.
//
// Ports
//   CLK        in   clock, rising edge
//   INIT_n     in   asynchronous active-low reset
//   RUN        in   level: start windows and keep them running back to back
//   CLR        in   synchronous abort of the window in progress; clears OVERRUN
//   IN         in   stochastic magnitude bit
//   SIGN_IN    in   sign paired with IN (1 = negative)
//   OUT_VAL    out  signed result, WIN_LOG2+2 bits
//   OUT_VALID  out  OUT_VAL holds an unconsumed result
//   OUT_READY  in   consumer accepts OUT_VAL when OUT_VALID & OUT_READY
//   BUSY       out  a window is being accumulated
//   OVERRUN    out  sticky: a completed window was dropped
//   OUT_MAG    out  |result|, WIN_LOG2+1 bits (ISTRA_DEC_SIGNMAG_EN only)
//   SIGN_OUT   out  result is negative (ISTRA_DEC_SIGNMAG_EN only)

module istra_stream_decoder #(
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic                CLK,
  input  logic                INIT_n,
  input  logic                RUN,
  input  logic                CLR,
  input  logic                IN,
  input  logic                SIGN_IN,
  output logic [WIN_LOG2+1:0] OUT_VAL,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                BUSY,
  output logic                OVERRUN
`ifdef ISTRA_DEC_SIGNMAG_EN
  ,
  output logic [WIN_LOG2:0]   OUT_MAG,
  output logic                SIGN_OUT
`endif
);

  localparam int unsigned AccW = WIN_LOG2 + 2;

  localparam logic [AccW-1:0]     AccOne = {{(AccW-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] CntOne = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e              state_q, state_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [AccW-1:0]     inc, sum;
  logic [AccW-1:0]     val_q;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                offer, load, drop;

  // +1 / -1 / 0 per sample, two's complement at accumulator width
  always_comb begin
    inc = '0;
    if (IN) begin
      inc = SIGN_IN ? '1 : AccOne;
    end
  end

  // Final sum of a window includes the increment of the last sample itself
  assign sum = acc_q + inc;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    offer   = 1'b0;
    if (CLR) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          acc_d = '0;
          cnt_d = '0;
          if (RUN) begin
            state_d = StAccum;
          end
        end
        StAccum: begin
          acc_d = sum;
          cnt_d = cnt_q + CntOne;  // wraps to 0 after the last sample
          if (cnt_q == CntMax) begin
            offer   = 1'b1;
            acc_d   = '0;
            state_d = RUN ? StAccum : StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load can replace a result that is being consumed on the same clock
  assign load = offer & (~valid_q | OUT_READY);
  assign drop = offer & valid_q & ~OUT_READY;

  always_comb begin
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && OUT_READY) begin
      valid_d = 1'b0;
    end
  end

  assign ovr_d = CLR ? 1'b0 : (ovr_q | drop);

  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (load) begin
        val_q <= sum;
      end
    end
  end

  assign OUT_VAL   = val_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = (state_q == StAccum);
  assign OVERRUN   = ovr_q;

`ifdef ISTRA_DEC_SIGNMAG_EN
  localparam logic [WIN_LOG2:0] MagOne = {{WIN_LOG2{1'b0}}, 1'b1};

  logic               sum_neg;
  logic [WIN_LOG2:0]  sum_mag;
  logic [WIN_LOG2:0]  mag_q;
  logic               sign_q;

  // Negating in WIN_LOG2+1 bits is exact: -2**WIN_LOG2 maps to 2**WIN_LOG2
  assign sum_neg = sum[AccW-1];
  assign sum_mag = sum_neg ? (~sum[WIN_LOG2:0] + MagOne) : sum[WIN_LOG2:0];

  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
    end else if (load) begin
      mag_q  <= sum_mag;
      sign_q <= sum_neg;
    end
  end

  assign OUT_MAG  = mag_q;
  assign SIGN_OUT = sign_q;
`endif

endmodule

// File: tb/tb_istra_stream_decoder.sv
// Directed self-checking bench for istra_stream_decoder with WIN_LOG2 = 4.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.

module tb_istra_stream_decoder;

  localparam int unsigned W = 4;

  logic         CLK;
  logic         INIT_n;
  logic         RUN;
  logic         CLR;
  logic         IN;
  logic         SIGN_IN;
  logic [W+1:0] OUT_VAL;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         BUSY;
  logic         OVERRUN;
`ifdef ISTRA_DEC_SIGNMAG_EN
  logic [W:0]   OUT_MAG;
  logic         SIGN_OUT;
`endif

  int checks;
  int failures;

  istra_stream_decoder #(
    .WIN_LOG2(W)
  ) dut (
    .CLK      (CLK),
    .INIT_n   (INIT_n),
    .RUN      (RUN),
    .CLR      (CLR),
    .IN       (IN),
    .SIGN_IN  (SIGN_IN),
    .OUT_VAL  (OUT_VAL),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .BUSY     (BUSY),
    .OVERRUN  (OVERRUN)
`ifdef ISTRA_DEC_SIGNMAG_EN
    ,
    .OUT_MAG  (OUT_MAG),
    .SIGN_OUT (SIGN_OUT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive n samples; bit i of each mask is the value in front of the i-th edge
  task automatic run_samples(input int n, input logic [15:0] in_m,
                             input logic [15:0] sign_m, input logic [15:0] rdy_m);
    for (int i = 0; i < n; i++) begin
      IN        = in_m[i];
      SIGN_IN   = sign_m[i];
      OUT_READY = rdy_m[i];
      step();
    end
  endtask

  task automatic check_val(input string tag, input logic signed [31:0] exp);
    check(tag, 32'($signed(OUT_VAL)), exp);
`ifdef ISTRA_DEC_SIGNMAG_EN
    check({tag, "_mag"}, 32'(OUT_MAG), (exp < 0) ? -exp : exp);
    check({tag, "_sign"}, 32'(SIGN_OUT), (exp < 0) ? 32'sd1 : 32'sd0);
`endif
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    INIT_n    = 1'b0;
    RUN       = 1'b0;
    CLR       = 1'b0;
    IN        = 1'b0;
    SIGN_IN   = 1'b0;
    OUT_READY = 1'b0;

    // Reset state
    step();
    step();
    check_val("rst_val", 0);
    check("rst_valid", 32'(OUT_VALID), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_ovr", 32'(OVERRUN), 0);
    INIT_n = 1'b1;
    step();
    check("idle_busy", 32'(BUSY), 0);

    // All positive ones, back to back, consumer always ready
    RUN       = 1'b1;
    OUT_READY = 1'b1;
    step();
    check("start_busy", 32'(BUSY), 1);
    run_samples(15, 16'hFFFF, 16'h0000, 16'hFFFF);
    check("pos_not_yet", 32'(OUT_VALID), 0);
    run_samples(1, 16'hFFFF, 16'h0000, 16'hFFFF);
    check_val("pos1_val", 16);
    check("pos1_valid", 32'(OUT_VALID), 1);
    run_samples(16, 16'hFFFF, 16'h0000, 16'hFFFF);
    check_val("pos2_val", 16);
    check("pos2_valid", 32'(OUT_VALID), 1);
    check("pos2_ovr", 32'(OVERRUN), 0);
    check("pos2_busy", 32'(BUSY), 1);

    // Mixed: 12 negative, 4 positive
    run_samples(16, 16'hFFFF, 16'h0FFF, 16'hFFFF);
    check_val("mix_val", -8);
    check("mix_valid", 32'(OUT_VALID), 1);

    // All zeros; RUN low so the FSM idles after this window
    RUN = 1'b0;
    run_samples(16, 16'h0000, 16'h0000, 16'hFFFF);
    check_val("zero_val", 0);
    check("zero_valid", 32'(OUT_VALID), 1);
    check("zero_busy", 32'(BUSY), 0);
    step();
    check("zero_consumed", 32'(OUT_VALID), 0);

    // Overrun: consumer stalled across +16 then -16
    OUT_READY = 1'b0;
    RUN       = 1'b1;
    step();
    run_samples(16, 16'hFFFF, 16'h0000, 16'h0000);
    check_val("ovr1_val", 16);
    check("ovr1_valid", 32'(OUT_VALID), 1);
    check("ovr1_ovr", 32'(OVERRUN), 0);
    RUN = 1'b0;
    run_samples(16, 16'hFFFF, 16'hFFFF, 16'h0000);
    check_val("ovr2_val", 16);
    check("ovr2_ovr", 32'(OVERRUN), 1);
    check("ovr2_busy", 32'(BUSY), 0);
    OUT_READY = 1'b1;
    step();
    check("ovr_consumed", 32'(OUT_VALID), 0);
    check("ovr_sticky", 32'(OVERRUN), 1);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("ovr_clr", 32'(OVERRUN), 0);
    check("ovr_clr_valid", 32'(OUT_VALID), 0);

    // Consume and completion on the same clock
    OUT_READY = 1'b0;
    RUN       = 1'b1;
    step();
    run_samples(16, 16'hFFFF, 16'h0000, 16'h0000);
    check_val("sim1_val", 16);
    RUN = 1'b0;
    run_samples(16, 16'hFFFF, 16'hFFFF, 16'h8000);
    check_val("sim2_val", -16);
    check("sim2_valid", 32'(OUT_VALID), 1);
    check("sim2_ovr", 32'(OVERRUN), 0);
    check("sim2_busy", 32'(BUSY), 0);
    step();
    check("sim_consumed", 32'(OUT_VALID), 0);

    // RUN dropped at sample 5; window still completes (13 - 3 = 10)
    RUN = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      if (i == 4) RUN = 1'b0;
      IN        = 1'b1;
      SIGN_IN   = (i < 3);
      OUT_READY = 1'b1;
      step();
      if (i == 14) check("drop_busy_mid", 32'(BUSY), 1);
    end
    check_val("drop_val", 10);
    check("drop_valid", 32'(OUT_VALID), 1);
    check("drop_busy_end", 32'(BUSY), 0);

    // CLR at sample 9: no result, IDLE next clock, held result untouched
    OUT_READY = 1'b0;
    RUN       = 1'b1;
    step();
    run_samples(8, 16'hFFFF, 16'h0000, 16'h0000);
    CLR = 1'b1;
    RUN = 1'b0;
    IN  = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_busy", 32'(BUSY), 0);
    run_samples(16, 16'hFFFF, 16'h0000, 16'h0000);
    check_val("clr_val_kept", 10);
    check("clr_valid_kept", 32'(OUT_VALID), 1);
    check("clr_ovr", 32'(OVERRUN), 0);
    check("clr_idle", 32'(BUSY), 0);

    // Asynchronous reset at sample 7, then a fresh full window (14 - 2 = 12)
    RUN = 1'b1;
    step();
    run_samples(7, 16'hFFFF, 16'h0000, 16'h0000);
    INIT_n = 1'b0;
    #1;
    check("arst_val", 32'($signed(OUT_VAL)), 0);
    check("arst_valid", 32'(OUT_VALID), 0);
    check("arst_busy", 32'(BUSY), 0);
    check("arst_ovr", 32'(OVERRUN), 0);
    #1;
    INIT_n = 1'b1;
    step();
    check("fresh_busy", 32'(BUSY), 1);
    RUN = 1'b0;
    run_samples(15, 16'hFFFF, 16'h0003, 16'hFFFF);
    check("fresh_not_yet", 32'(OUT_VALID), 0);
    run_samples(1, 16'h0001, 16'h0000, 16'h0000);
    check_val("fresh_val", 12);
    check("fresh_valid", 32'(OUT_VALID), 1);
    check("fresh_busy_end", 32'(BUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
